// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock-enable divider, h/v counters, sync decode and line/frame strobes.
// Define VGA_FRAME_CNT_EN to add the wrapping 8-bit frame_cnt_o output.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DIV  = 4,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       valid_o,
    output logic       pix_tick_o,
    output logic       line_start_o,
    output logic       frame_start_o
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt_o
`endif
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
    // Keep the divider at least one bit wide so PIX_DIV = 1 still elaborates.
    localparam int unsigned DivW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]      h_cnt_q, h_cnt_d;
    logic [9:0]      v_cnt_q, v_cnt_d;
    logic            run_q, run_d;
    logic            line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d;
    logic            pix_tick;
    logic            h_last;
    logic            v_last;

    assign pix_tick = (div_cnt_q == DivW'(PIX_DIV - 1));
    assign h_last   = (h_cnt_q == 10'(H_TOTAL - 1));
    assign v_last   = (v_cnt_q == 10'(V_TOTAL - 1));

    always_comb begin
        div_cnt_d     = pix_tick ? '0 : div_cnt_q + DivW'(1);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        run_d         = run_q | pix_tick;
        line_start_d  = pix_tick & h_last;
        frame_start_d = pix_tick & h_last & v_last;
        if (pix_tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            run_q         <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            run_q         <= run_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_cnt_q + {7'd0, frame_start_d};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

    // Sync decodes come straight off the counter registers so they line up with h_cnt/v_cnt.
    assign hsync_o = ((h_cnt_q >= 10'(HS_START)) && (h_cnt_q <= 10'(HS_END))) ? SYNC_POL
                                                                               : ~SYNC_POL;
    assign vsync_o = ((v_cnt_q >= 10'(VS_START)) && (v_cnt_q <= 10'(VS_END))) ? SYNC_POL
                                                                               : ~SYNC_POL;
    assign valid_o = run_q && (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));

    assign h_cnt_o       = h_cnt_q;
    assign v_cnt_o       = v_cnt_q;
    assign pix_tick_o    = pix_tick;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two instances (PIX_DIV=3/active-low, PIX_DIV=1/active-high)
// on a reduced raster, random run lengths and asynchronous resets, checked every cycle.
module tb_vga_timing_gen;

    localparam int unsigned HA = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned D0 = 3;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       valid;
        logic       tick;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] h0, v0, h1, v1;
    logic       hs0, vs0, val0, tk0, ls0, fs0;
    logic       hs1, vs1, val1, tk1, ls1, fs1;
    logic [7:0] fc0, fc1;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_DIV(D0), .SYNC_POL(1'b0)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .h_cnt_o(h0), .v_cnt_o(v0),
        .hsync_o(hs0), .vsync_o(vs0), .valid_o(val0), .pix_tick_o(tk0),
        .line_start_o(ls0), .frame_start_o(fs0)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt_o(fc0)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_DIV(1), .SYNC_POL(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .h_cnt_o(h1), .v_cnt_o(v1),
        .hsync_o(hs1), .vsync_o(vs1), .valid_o(val1), .pix_tick_o(tk1),
        .line_start_o(ls1), .frame_start_o(fs1)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt_o(fc1)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc0 = 8'd0;
    assign fc1 = 8'd0;
`endif

    // Reference: after e clock edges since reset release, e/d pixels have elapsed.
    function automatic obs_t model(int unsigned e, int unsigned d, logic pol);
        obs_t        o;
        int unsigned p    = e / d;
        int unsigned h    = p % HT;
        int unsigned v    = (p / HT) % VT;
        bit          tedg = (e > 0) && (e % d == 0);
        o.h     = 10'(h);
        o.v     = 10'(v);
        o.hs    = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
        o.vs    = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
        o.valid = (p >= 1) && (h < HA) && (v < VA);
        o.tick  = (e % d) == (d - 1);
        o.ls    = tedg && (h == 0);
        o.fs    = tedg && (h == 0) && (v == 0);
`ifdef VGA_FRAME_CNT_EN
        o.fc    = 8'((p / (HT * VT)) % 256);
`else
        o.fc    = 8'd0;
`endif
        return o;
    endfunction

    obs_t        q0[$];
    obs_t        q1[$];
    int unsigned e = 0;
    int          total = 0;
    int          bad = 0;

    task automatic push_both();
        q0.push_back(model(e, D0, 1'b0));
        q1.push_back(model(e, 1, 1'b1));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) e++;
        push_both();
    endtask

    task automatic assert_reset(int unsigned hold);
        @(posedge clk);
        #2 rst_n = 1'b0;
        e = 0;
        push_both();
        repeat (hold) step();
        #2 rst_n = 1'b1;
    endtask

    task automatic check(string name, obs_t act, obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b val=%b tick=%b ls=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b val=%b tick=%b ls=%b fs=%b fc=%0d",
                     name, $time, act.h, act.v, act.hs, act.vs, act.valid, act.tick, act.ls,
                     act.fs, act.fc, exp.h, exp.v, exp.hs, exp.vs, exp.valid, exp.tick, exp.ls,
                     exp.fs, exp.fc);
        end
    endtask

    // Monitor: one expected entry per cycle per instance, compared away from the active edge.
    always @(negedge clk) begin
        if (q0.size() > 0) check("div3_lowpol", {h0, v0, hs0, vs0, val0, tk0, ls0, fs0, fc0},
                                 q0.pop_front());
        if (q1.size() > 0) check("div1_highpol", {h1, v1, hs1, vs1, val1, tk1, ls1, fs1, fc1},
                                 q1.pop_front());
    end

    initial begin
        repeat (3) step();
        #2 rst_n = 1'b1;
        // Two full frames of the slow instance, then random mid-frame resets.
        repeat (2 * HT * VT * D0 + 17) step();
        for (int s = 0; s < 12; s++) begin
            assert_reset($urandom_range(0, 3));
            repeat ($urandom_range(5, 900)) step();
        end
`ifdef VGA_FRAME_CNT_EN
        // 257+ frames of the fast instance to cover the frame counter wrap.
        assert_reset(1);
        repeat (257 * HT * VT + 40) step();
`endif
        @(negedge clk);
        #1;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster timing that drives the VGA display path: horizontal/vertical pixel counters, hsync/vsync, the active-video qualifier, and line/frame strobes.
- h_cnt/v_cnt feed the pixel address generator and the game-state logic; hsync/vsync go straight to the connector.
- Runs from the system clock, with an internal pixel clock-enable divider (100 MHz / 4 = 25 MHz for 640x480@60).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIX_DIV, 4, clk cycles per pixel (>=1)
SYNC_POL, 0, asserted sync level (0 = active-low pulses)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-low reset
h_cnt  out  10  current pixel column, 0..H_TOTAL-1
v_cnt  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
valid  out  1  high while (h_cnt,v_cnt) is inside the active area
pix_tick  out  1  one-clk pulse; counters advance on this cycle
line_start  out  1  one-clk pulse when h_cnt becomes 0
frame_start  out  1  one-clk pulse when (h_cnt,v_cnt) becomes (0,0)
frame_cnt  out  8  frames completed, wraps (only with VGA_FRAME_CNT_EN)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider div_cnt counts 0..PIX_DIV-1 and wraps.
- pix_tick is combinational: high when div_cnt == PIX_DIV-1.
- With PIX_DIV = 1, pix_tick is constantly 1 after reset.
- On the clk edge with pix_tick high:
  - if h_cnt == H_TOTAL-1: h_cnt <= 0, else h_cnt += 1.
  - On the h wrap, v_cnt increments; if v_cnt == V_TOTAL-1, v_cnt <= 0.
- Counters never take values >= their total.
- Sync decodes are combinational from the counter registers, zero latency, so sync is aligned with h_cnt/v_cnt:
  - hsync asserted iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync asserted iff v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - Asserted level = SYNC_POL; deasserted level = ~SYNC_POL.
- Run flag:
  - Cleared by reset; set on the first pix_tick after reset release.
  - valid = run & (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- Strobes:
  - line_start is registered: high for exactly one clk, the cycle after the edge that wrapped h_cnt to 0.
  - frame_start is registered the same way, for the edge that wrapped both counters to 0.
  - frame_start implies line_start in the same cycle.
- Reset (async, rst == 0), applied immediately, including mid-line or mid-frame:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0, run = 0.
  - valid = 0, line_start = 0, frame_start = 0, frame_cnt = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
- Reset release: the first pix_tick occurs PIX_DIV clks later. No strobe is generated for the initial (0,0) position.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: the frame_cnt port and its register exist. frame_cnt increments on the same edge that wraps to (0,0), so it is updated when frame_start goes high. It wraps 255 -> 0.
- Undefined: the frame_cnt port and its logic are removed. All other behaviour is identical.

Test Plan:
- Release reset, default parameters -> first pix_tick 4 clks later. h_cnt steps 0,1,2 every 4 clks. valid=0 before the first tick and 1 after it.
- Run one line -> line_start pulses every 3200 clks. hsync low exactly while h_cnt=656..751 (384 clks). valid high for h_cnt 0..639 only.
- Run a full frame -> frame_start period = 1,680,000 clks. vsync low exactly for v_cnt 490..491 (6400 clks). Count of valid pix_ticks per frame = 307,200.
- Assert rst mid-frame at h_cnt=300, v_cnt=200 -> all outputs return to reset values immediately (no clk edge needed). Restart behaves as in the first scenario.
- PIX_DIV=1, SYNC_POL=1 -> pix_tick constantly high after reset. hsync high for h_cnt 656..751. Line period = 800 clks.
- With VGA_FRAME_CNT_EN: 257 frames -> frame_cnt reads 1 after the 257th frame_start. Build without the macro -> compiles with no frame_cnt port.
